// File: rtl/spi_cmd_pkg.sv
// Shared command-byte layout and decoder state encoding for the SPI
// instruction decoder.
//   CMD_RW_BIT   : command bit selecting write (1) or read (0)
//   CMD_HL_BIT   : command bit selecting high (1) or low (0) register byte
//   CMD_ADDR_MSB : top bit of the register address field
//   state_t      : decoder phase, S_CMD (expect command) / S_DATA (expect data)
//   RD_IDLE_BYTE : value on MISO whenever no read data is being returned
package spi_cmd_pkg;

  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_HL_BIT   = 6;
  localparam int CMD_ADDR_MSB = 5;

  typedef enum logic {
    S_CMD  = 1'b0,
    S_DATA = 1'b1
  } state_t;

  localparam logic [7:0] RD_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/spi_instr_decoder.sv
// Turns the SPI byte bridge's byte stream into 2-byte register transactions
// (command byte, then data byte) and returns read data on MISO.
//
// state  | meaning
// S_CMD  | next accepted byte is a command byte
// S_DATA | next byte is the data byte of the latched command
//
// Ports
//   i_clk        peripheral clock (shared with the bridge)
//   i_rst        synchronous active-high reset
//   i_cs_n       chip select, already in the clk domain
//   i_byte_sync  1-clk pulse: i_data_in holds a complete byte
//   i_data_in    received byte
//   o_data_out   byte presented to the bridge for MISO
//   o_reg_addr   register address
//   o_byte_sel   0 = low byte, 1 = high byte
//   o_write      1-clk write strobe
//   o_data_write write data, valid while o_write=1
//   o_read       1-clk read strobe
//   i_data_read  register file read data, combinational from addr/byte_sel
module spi_instr_decoder
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int MAX_ADDR = 63
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cs_n,
  input  logic              i_byte_sync,
  input  logic [7:0]        i_data_in,
  output logic [7:0]        o_data_out,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic              o_byte_sel,
  output logic              o_write,
  output logic [7:0]        o_data_write,
  output logic              o_read,
  input  logic [7:0]        i_data_read
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_byte_sel;
  logic              r_rw;
  logic              r_write;
  logic              r_read;
  logic              r_load;
  logic [7:0]        r_data_write;
  logic [7:0]        r_data_out;
  logic              w_in_range;

  // Widened compare so the check stays meaningful when MAX_ADDR covers the
  // whole address field.
  assign w_in_range = (32'(r_addr) <= MAX_ADDR);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_CMD;
      r_addr       <= '0;
      r_byte_sel   <= 1'b0;
      r_rw         <= 1'b0;
      r_write      <= 1'b0;
      r_read       <= 1'b0;
      r_load       <= 1'b0;
      r_data_write <= 8'h00;
      r_data_out   <= RD_IDLE_BYTE;
    end else begin
      r_write <= 1'b0;
      r_read  <= 1'b0;
      // r_load trails the read strobe by one cycle so the register file has
      // a full cycle to settle on the new address before data_out samples it.
      r_load  <= r_read;
      case (r_state)
        S_CMD: begin
          if (i_byte_sync && !i_cs_n) begin
            r_addr     <= i_data_in[ADDR_W-1:0];
            r_byte_sel <= i_data_in[CMD_HL_BIT];
            r_rw       <= i_data_in[CMD_RW_BIT];
            r_read     <= ~i_data_in[CMD_RW_BIT];
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (i_byte_sync) begin
            // cs_n rising in this same cycle is handled next cycle in S_CMD,
            // where the byte_sync-less cs_n=1 simply idles.
            if (r_rw && w_in_range) begin
              r_write      <= 1'b1;
              r_data_write <= i_data_in;
            end
            r_data_out <= RD_IDLE_BYTE;
            r_load     <= 1'b0;
            r_state    <= S_CMD;
          end else if (i_cs_n) begin
            r_data_out <= RD_IDLE_BYTE;
            r_load     <= 1'b0;
            r_state    <= S_CMD;
          end else if (r_load) begin
            r_data_out <= w_in_range ? i_data_read : RD_IDLE_BYTE;
          end
        end
        default: r_state <= S_CMD;
      endcase
    end
  end

  assign o_data_out   = r_data_out;
  assign o_reg_addr   = r_addr;
  assign o_byte_sel   = r_byte_sel;
  assign o_write      = r_write;
  assign o_data_write = r_data_write;
  assign o_read       = r_read;

endmodule

// File: tb/tb_spi_instr_decoder.sv
module tb_spi_instr_decoder;
  import spi_cmd_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       cs_n = 1'b1;
  logic       byte_sync = 1'b0;
  logic [7:0] data_in = 8'h00;

  // dut0: full address range, dut1: MAX_ADDR=15, same stimulus
  logic [7:0] d0_out, d0_wd, d0_rdata, d1_out, d1_wd, d1_rdata;
  logic [5:0] d0_addr, d1_addr;
  logic       d0_bs, d0_wr, d0_rd, d1_bs, d1_wr, d1_rd;

  spi_instr_decoder #(.ADDR_W(6), .MAX_ADDR(63)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_cs_n(cs_n), .i_byte_sync(byte_sync),
    .i_data_in(data_in), .o_data_out(d0_out), .o_reg_addr(d0_addr),
    .o_byte_sel(d0_bs), .o_write(d0_wr), .o_data_write(d0_wd),
    .o_read(d0_rd), .i_data_read(d0_rdata));

  spi_instr_decoder #(.ADDR_W(6), .MAX_ADDR(15)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_cs_n(cs_n), .i_byte_sync(byte_sync),
    .i_data_in(data_in), .o_data_out(d1_out), .o_reg_addr(d1_addr),
    .o_byte_sel(d1_bs), .o_write(d1_wr), .o_data_write(d1_wd),
    .o_read(d1_rd), .i_data_read(d1_rdata));

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] init_byte(int i);
    if (i == 37) return 8'hA7;          // addr 0x12, high byte
    return 8'(i * 7 + 1);
  endfunction

  // Register files seen by each DUT, updated by the DUT's own write strobes
  logic [7:0] mem0 [128];
  logic [7:0] mem1 [128];
  assign d0_rdata = mem0[{d0_addr, d0_bs}];
  assign d1_rdata = mem1[{d1_addr, d1_bs}];
  always @(posedge clk) begin
    if (d0_wr) mem0[{d0_addr, d0_bs}] <= d0_wd;
    if (d1_wr) mem1[{d1_addr, d1_bs}] <= d1_wd;
  end

  // Transaction-level reference: per instance, which phase we are in, the
  // latched command, and how many edges remain until read data must appear.
  logic [7:0] mdl_mem [2][128];
  bit         m_valid = 1'b0;
  bit         m_in_data [2];
  bit         m_rw [2];
  logic [5:0] m_addr [2];
  bit         m_hl [2];
  bit         m_wr [2];
  bit         m_rd [2];
  logic [7:0] m_wdata [2];
  logic [7:0] m_dout [2];
  int         m_load [2];

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem0[i] <= init_byte(i);
      mem1[i] <= init_byte(i);
      mdl_mem[0][i] = init_byte(i);
      mdl_mem[1][i] = init_byte(i);
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_in_data[k] = 1'b0; m_rw[k] = 1'b0; m_addr[k] = '0; m_hl[k] = 1'b0;
        m_wr[k] = 1'b0; m_rd[k] = 1'b0; m_dout[k] = 8'h00; m_load[k] = 0;
        m_valid = 1'b1;
      end else begin
        bit ok;
        bit was_data;
        ok = (int'(m_addr[k]) <= ((k == 0) ? 63 : 15));
        was_data = m_in_data[k];
        m_wr[k] = 1'b0;
        m_rd[k] = 1'b0;
        if (was_data && (byte_sync || cs_n)) begin
          if (byte_sync && m_rw[k] && ok) begin
            m_wr[k] = 1'b1;
            m_wdata[k] = data_in;
            mdl_mem[k][{m_addr[k], m_hl[k]}] = data_in;
          end
          m_dout[k] = 8'h00;
          m_load[k] = 0;
          m_in_data[k] = 1'b0;
        end else if (m_load[k] == 1) begin
          m_dout[k] = ok ? mdl_mem[k][{m_addr[k], m_hl[k]}] : 8'h00;
          m_load[k] = 0;
        end else if (m_load[k] == 2) begin
          m_load[k] = 1;
        end
        if (!was_data && byte_sync && !cs_n) begin
          m_rw[k]   = data_in[7];
          m_hl[k]   = data_in[6];
          m_addr[k] = data_in[5:0];
          m_in_data[k] = 1'b1;
          if (!data_in[7]) begin
            m_rd[k] = 1'b1;
            m_load[k] = 2;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic cmp_inst(input int k, input logic [7:0] o, input logic [5:0] a,
                          input logic b, input logic w, input logic [7:0] wd,
                          input logic r);
    chk("data_out", k, 32'(o), 32'(m_dout[k]));
    chk("reg_addr", k, 32'(a), 32'(m_addr[k]));
    chk("byte_sel", k, 32'(b), 32'(m_hl[k]));
    chk("write",    k, 32'(w), 32'(m_wr[k]));
    chk("read",     k, 32'(r), 32'(m_rd[k]));
    if (m_wr[k]) chk("data_write", k, 32'(wd), 32'(m_wdata[k]));
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      cmp_inst(0, d0_out, d0_addr, d0_bs, d0_wr, d0_wd, d0_rd);
      cmp_inst(1, d1_out, d1_addr, d1_bs, d1_wr, d1_wd, d1_rd);
    end
  end

  // Strobe monitor for the hand-computed expectations
  int         wr_cnt [2];
  int         rd_cnt [2];
  logic [7:0] last_wd [2];
  logic [5:0] last_wa [2];
  logic       last_wb [2];
  always @(negedge clk) begin
    if (d0_wr) begin wr_cnt[0]++; last_wd[0] = d0_wd; last_wa[0] = d0_addr; last_wb[0] = d0_bs; end
    if (d1_wr) begin wr_cnt[1]++; last_wd[1] = d1_wd; last_wa[1] = d1_addr; last_wb[1] = d1_bs; end
    if (d0_rd) rd_cnt[0]++;
    if (d1_rd) rd_cnt[1]++;
  end

  task automatic clr_cnt();
    for (int k = 0; k < 2; k++) begin wr_cnt[k] = 0; rd_cnt[k] = 0; end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; returns on the negedge after the capturing posedge
  task automatic send(input logic [7:0] b);
    byte_sync = 1'b1;
    data_in = b;
    @(negedge clk);
    byte_sync = 1'b0;
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("rst_data_out", 0, 32'(d0_out), 32'h00);
    chk("rst_write", 0, 32'(d0_wr), 32'h0);

    // write 0x85,0x3C -> addr 5 low byte = 0x3C
    cs_n = 1'b0; tick(2); clr_cnt();
    send(8'h85); tick(6); send(8'h3C); tick(2);
    chk("wr_pulses", 0, wr_cnt[0], 1);
    chk("wr_pulses", 1, wr_cnt[1], 1);
    chk("wr_data", 0, 32'(last_wd[0]), 32'h3C);
    chk("wr_addr", 0, 32'(last_wa[0]), 32'd5);
    chk("wr_bsel", 0, 32'(last_wb[0]), 32'd0);
    chk("wr_no_read", 0, rd_cnt[0], 0);
    cs_n = 1'b1; tick(2);

    // read 0x52 -> addr 0x12 high byte = 0xA7
    cs_n = 1'b0; tick(2); clr_cnt();
    byte_sync = 1'b1; data_in = 8'h52;
    @(negedge clk); byte_sync = 1'b0;
    chk("rd_pulse_t1", 0, 32'(d0_rd), 32'd1);
    chk("rd_dout_t1", 0, 32'(d0_out), 32'h00);
    tick(1);
    chk("rd_pulse_t2", 0, 32'(d0_rd), 32'd0);
    tick(1);
    chk("rd_dout_t2", 0, 32'(d0_out), 32'hA7);
    chk("rd_oor_dout", 1, 32'(d1_out), 32'h00);
    tick(4);
    chk("miso_byte2", 0, 32'(d0_out), 32'hA7);
    send(8'h00);
    chk("rd_dout_after", 0, 32'(d0_out), 32'h00);
    chk("rd_pulses", 0, rd_cnt[0], 1);
    tick(2); cs_n = 1'b1; tick(2);

    // out of range for dut1: write 0xBF,0x11 then read 0x3F
    cs_n = 1'b0; tick(1); clr_cnt();
    send(8'hBF); tick(5); send(8'h11); tick(2);
    chk("oor_no_write", 1, wr_cnt[1], 0);
    chk("inr_write", 0, wr_cnt[0], 1);
    send(8'h3F); tick(2);
    chk("oor_rd_dout", 1, 32'(d1_out), 32'h00);
    chk("inr_rd_dout", 0, 32'(d0_out), 32'h11);
    send(8'h00); tick(2); cs_n = 1'b1; tick(2);

    // abort after command 0x81, then 0x02 is a fresh read command
    cs_n = 1'b0; tick(1); clr_cnt();
    send(8'h81); tick(4); cs_n = 1'b1; tick(3);
    chk("abort_no_write", 0, wr_cnt[0], 0);
    cs_n = 1'b0; tick(2);
    send(8'h02); tick(2);
    chk("abort_next_addr", 0, 32'(d0_addr), 32'd2);
    chk("abort_next_rd", 0, rd_cnt[0], 1);
    chk("abort_next_dout", 0, 32'(d0_out), 32'h1D);
    chk("abort_no_write2", 0, wr_cnt[0], 0);
    send(8'h00); tick(2); cs_n = 1'b1; tick(2);

    // back-to-back write 0x83,0x55 then read 0x03
    cs_n = 1'b0; tick(1); clr_cnt();
    send(8'h83); tick(4); send(8'h55); tick(4); send(8'h03); tick(2);
    chk("b2b_dout", 0, 32'(d0_out), 32'h55);
    chk("b2b_wr", 0, wr_cnt[0], 1);
    chk("b2b_rd", 0, rd_cnt[0], 1);
    send(8'h00); tick(2); cs_n = 1'b1; tick(2);

    // byte with cs_n high in S_CMD is ignored; byte with cs_n rising in
    // S_DATA is still processed
    clr_cnt();
    send(8'h85); tick(3);
    chk("csn_hi_ignored", 0, wr_cnt[0] + rd_cnt[0], 0);
    cs_n = 1'b0; tick(1);
    send(8'h84); tick(3);
    cs_n = 1'b1; send(8'h66); tick(2);
    chk("csn_edge_wr", 0, wr_cnt[0], 1);
    chk("csn_edge_wd", 0, 32'(last_wd[0]), 32'h66);
    tick(2);

    // reset one clock after a read command
    cs_n = 1'b0; tick(1); clr_cnt();
    byte_sync = 1'b1; data_in = 8'h52;
    @(negedge clk); byte_sync = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_read", 0, 32'(d0_rd), 32'd0);
    chk("rst_mid_dout", 0, 32'(d0_out), 32'h00);
    chk("rst_mid_state", 0, 32'(u_dut0.r_state), 32'(S_CMD));
    rst = 1'b0; tick(3);
    chk("rst_no_late_load", 0, 32'(d0_out), 32'h00);
    send(8'h01); tick(2);
    chk("rst_next_cmd", 0, 32'(d0_addr), 32'd1);
    send(8'h00); tick(2); cs_n = 1'b1; tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
